// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// Module   : inst_fetch_pkg
// Purpose  : Shared types and default widths for the instruction fetch slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_if.sv
// ============================================================================
// Module   : inst_fetch_if
// Purpose  : ROM, redirect and decode-side handshake bundle of inst_fetch.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface inst_fetch_if #(
    parameter int ADDR_W = inst_fetch_pkg::DEF_ADDR_W,
    parameter int DATA_W = inst_fetch_pkg::DEF_DATA_W
);
    logic              fetch_en;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [DATA_W-1:0] rom_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        input  fetch_en, rom_data, redirect_valid, redirect_pc, out_ready,
        output rom_addr, rom_en, out_valid, out_inst, out_pc
    );

    modport slave (
        output fetch_en, rom_data, redirect_valid, redirect_pc, out_ready,
        input  rom_addr, rom_en, out_valid, out_inst, out_pc
    );
endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Power-of-two prefetch FIFO with flush, count and registered head.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = inst_fetch_pkg::DEF_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [CNT_W-1:0] o_count,
    output logic                  o_valid,
    output logic      [WIDTH-1:0] o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // Pop is judged first so a push into a full FIFO is legal when the head leaves.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != C_DEPTH) || w_do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Purpose  : PC, ROM issue control and prefetch buffering for decode.
//            INST_FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  wire logic    clk,
    input  wire logic    rst,
    inst_fetch_if.master bus
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetch_cnt,
    output logic [31:0]  perf_stall_cnt
`endif
);
    localparam int                 CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int                 ENTRY_W = ADDR_W + DATA_W;
    localparam logic [CNT_W:0]     C_DEPTH = (CNT_W+1)'(FIFO_DEPTH);

    fetch_state_t        r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_inflight_pc;
    logic                r_inflight;

    logic [CNT_W-1:0]    w_count;
    logic                w_valid;
    logic [ENTRY_W-1:0]  w_head;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic [CNT_W:0]      w_occupancy;

    // Slots already promised: buffered entries plus the outstanding ROM read.
    assign w_pop       = w_valid && bus.out_ready;
    assign w_occupancy = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    assign w_issue     = (r_state == RUN) && bus.fetch_en && !bus.redirect_valid
                         && (w_occupancy < C_DEPTH);
    assign w_push      = r_inflight && !bus.redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state <= bus.fetch_en ? RUN : IDLE;
            if (bus.redirect_valid) begin
                r_pc       <= bus.redirect_pc;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_pc <= r_pc;
                    r_pc          <= r_pc + 1'b1;
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  ({r_inflight_pc, bus.rom_data}),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_head  (w_head)
    );

    assign bus.rom_addr  = r_pc;
    assign bus.rom_en    = w_issue;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_head[ENTRY_W-1:DATA_W];
    assign bus.out_inst  = w_head[DATA_W-1:0];

`ifdef INST_FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetch <= r_perf_fetch + 1'b1;
            end
            if ((r_state == RUN) && !w_issue && !bus.redirect_valid) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif
endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Directed self-checking bench for inst_fetch with a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    inst_fetch_if #(.ADDR_W(4),  .DATA_W(32)) bus1 ();

`ifdef INST_FETCH_PERF_EN
    logic [31:0] perf_fetch0, perf_stall0, perf_fetch1, perf_stall1;
`endif

    inst_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
`ifdef INST_FETCH_PERF_EN
        , .perf_fetch_cnt (perf_fetch0), .perf_stall_cnt (perf_stall0)
`endif
    );

    inst_fetch #(.ADDR_W(4), .DATA_W(32), .RESET_PC(4'hE), .FIFO_DEPTH(2)) u_dut_w4 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
`ifdef INST_FETCH_PERF_EN
        , .perf_fetch_cnt (perf_fetch1), .perf_stall_cnt (perf_stall1)
`endif
    );

    // Registered ROMs: word[a] = 0x1000 + a
    always @(posedge clk) begin
        bus0.rom_data <= 32'h1000 + bus0.rom_addr;
        bus1.rom_data <= 32'h1000 + {28'd0, bus1.rom_addr};
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state: FIFO contents as PCs, outstanding read, PC, run flag
    logic [31:0] m_q [$];
    logic [31:0] m_pc;
    logic [31:0] m_inf_pc;
    bit          m_inf;
    bit          m_run;
    int          m_pops;
    int          m_stall;

    logic        log_v  [512];
    logic [31:0] log_pc [512];
    logic        log_en [512];

    logic [3:0]  exp4 [6] = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3};
    int          k2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_pc     = 32'h0;
        m_inf    = 1'b0;
        m_inf_pc = 32'h0;
        m_run    = 1'b0;
        m_pops   = 0;
        m_stall  = 0;
        k2       = 0;
    endtask

    task automatic reset_checks();
        chk("rst_rom_addr",  bus0.rom_addr,  32'h0);
        chk("rst_rom_en",    bus0.rom_en,    1'b0);
        chk("rst_out_valid", bus0.out_valid, 1'b0);
        chk("rst_out_inst",  bus0.out_inst,  32'h0);
        chk("rst_out_pc",    bus0.out_pc,    32'h0);
        chk("rst_w4_addr",   bus1.rom_addr,  4'hE);
    endtask

    // One cycle: drive at negedge, check just after, advance model, cross posedge.
    task automatic step(input bit fen, input bit rdy, input bit rv, input logic [31:0] rpc);
        bit          exp_valid;
        bit          pop;
        bit          exp_en;
        logic [31:0] hpc;
        int          occ;
        bus0.fetch_en       = fen;
        bus0.out_ready      = rdy;
        bus0.redirect_valid = rv;
        bus0.redirect_pc    = rpc;
        #1;
        exp_valid = (m_q.size() > 0);
        hpc       = exp_valid ? m_q[0] : 32'h0;
        pop       = exp_valid && rdy;
        occ       = m_q.size() + int'(m_inf) - int'(pop);
        exp_en    = m_run && fen && !rv && (occ < 2);

        chk("rom_addr",  bus0.rom_addr,  m_pc);
        chk("rom_en",    bus0.rom_en,    exp_en);
        chk("out_valid", bus0.out_valid, exp_valid);
        if (exp_valid) begin
            chk("out_pc",   bus0.out_pc,   hpc);
            chk("out_inst", bus0.out_inst, hpc + 32'h1000);
        end
`ifdef INST_FETCH_PERF_EN
        chk("perf_fetch", perf_fetch0, m_pops);
        chk("perf_stall", perf_stall0, m_stall);
`endif
        if (bus1.out_valid && k2 < 6) begin
            chk("w4_pc",   bus1.out_pc,   exp4[k2]);
            chk("w4_inst", bus1.out_inst, 32'h1000 + {28'd0, exp4[k2]});
            k2++;
        end
        if (cyc < 512) begin
            log_v[cyc]  = bus0.out_valid;
            log_pc[cyc] = bus0.out_pc;
            log_en[cyc] = bus0.rom_en;
        end

        m_pops  += int'(pop);
        m_stall += int'(m_run && !exp_en && !rv);
        if (rv) begin
            m_q.delete();
            m_inf = 1'b0;
            m_pc  = rpc;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_inf) m_q.push_back(m_inf_pc);
            if (exp_en) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + 32'h1;
            end
            m_inf = exp_en;
        end
        m_run = fen;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int f_cyc, r_cyc, d_cyc, b_cyc, hits, en_hi;
        bit found;
        bus0.fetch_en = 0; bus0.out_ready = 0; bus0.redirect_valid = 0; bus0.redirect_pc = 0;
        bus1.fetch_en = 0; bus1.out_ready = 1; bus1.redirect_valid = 0; bus1.redirect_pc = 0;
        m_reset();
        @(negedge clk);
        #1;
        reset_checks();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus1.fetch_en = 1'b1;

        // Stream, then redirect to 0x40 while PC 5's response is arriving
        f_cyc = cyc;
        found = 1'b0;
        r_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            if (!found && m_inf && m_inf_pc == 32'h5) begin
                found = 1'b1;
                r_cyc = cyc;
                step(1, 1, 1, 32'h40);
            end else begin
                step(1, 1, 0, 32'h0);
            end
        end
        chk("redir_hit",    found,             1'b1);
        chk("first_lat_v2", log_v[f_cyc+2],    1'b0);
        chk("first_lat_v3", log_v[f_cyc+3],    1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("stream_pc", log_pc[f_cyc+3+i], 32'(i));
        end
        chk("redir_v3",  log_v[r_cyc+3],  1'b1);
        chk("redir_pc3", log_pc[r_cyc+3], 32'h40);
        chk("redir_pc4", log_pc[r_cyc+4], 32'h41);
        hits = 0;
        for (int i = f_cyc; i < cyc; i++) begin
            if (log_v[i] && log_pc[i] == 32'h5) hits++;
        end
        chk("pc5_dropped", hits, 0);
        chk("w4_seq_done", k2, 6);

        // fetch_en low: no issues, then resume sequentially
        d_cyc = cyc;
        for (int i = 0; i < 6; i++) step(0, 1, 0, 32'h0);
        en_hi = 0;
        for (int i = 0; i < 6; i++) en_hi += int'(log_en[d_cyc+i]);
        chk("fen_off_no_issue", en_hi, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h0);

        // Asynchronous reset mid-run
        rst = 1'b0;
        #1;
        reset_checks();
        m_reset();
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Backpressure from restart: head holds PC 0 for 6 cycles
        b_cyc = cyc;
        for (int i = 0; i < 9; i++)  step(1, 0, 0, 32'h0);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 32'h0);
        chk("bp_issue1",  log_en[b_cyc+1], 1'b1);
        chk("bp_issue2",  log_en[b_cyc+2], 1'b1);
        chk("bp_full_en", log_en[b_cyc+4], 1'b0);
        chk("bp_head3",   log_pc[b_cyc+3], 32'h0);
        chk("bp_head8",   log_pc[b_cyc+8], 32'h0);
        chk("bp_valid8",  log_v[b_cyc+8],  1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_release_pc", log_pc[b_cyc+9+i], 32'(i));
        end
        chk("w4_seq_again", k2, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
